if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC register and the IF/ID pipeline register.
//   Drives pc_o to instruction memory and to the PC+4 adder. Takes the adder's sum back as pc_plus4_i.
//   Selects the next PC (sequential / branch / jump) under hazard-unit stall and flush control.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC value loaded on reset
//   NOP_INSTR  32'h0000_0000   instruction injected into IF/ID on flush (sll $0,$0,0)
// PORTS
//   clk              in   1   single clock, rising-edge
//   rst_n            in   1   asynchronous, active-low reset
//   stall_i          in   1   hazard unit: hold PC and IF/ID
//   flush_i          in   1   squash instruction currently entering IF/ID
//   branch_taken_i   in   1   branch resolved taken in ID
//   branch_target_i  in   32  branch target address
//   jump_i           in   1   j/jal decoded in ID
//   jump_target_i    in   32  jump target address
//   pc_plus4_i       in   32  pc_o + 4 from the PC adder
//   instr_i          in   32  instruction memory read data for pc_o
//   pc_o             out  32  current PC
//   if_id_pc4_o      out  32  IF/ID latched PC+4
//   if_id_instr_o    out  32  IF/ID latched instruction
//   if_id_valid_o    out  1   IF/ID holds a real instruction
//   fetch_cnt_o      out  32  committed fetches (PERF_CNT_EN only)
//   stall_cnt_o      out  32  stalled cycles (PERF_CNT_EN only)
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     pc_o=RESET_PC, if_id_pc4_o=0, if_id_instr_o=NOP_INSTR, if_id_valid_o=0, counters=0, state=BOOT.
//   FSM states:
//     BOOT: exactly 1 cycle after reset release, imem settles, IF/ID not written, PC held -> RUN.
//     RUN: normal fetch. stall_i=1 -> HOLD.
//     HOLD: stall_i=0 -> RUN.
//   Next PC priority, evaluated every edge in RUN/HOLD:
//     jump_i > branch_taken_i > stall_i > pc_plus4_i.
//     A redirect overrides an active stall.
//   Target addresses: bits [1:0] are forced to 2'b00. No other arithmetic is done here; PC+4 comes from the external adder.
//   IF/ID update on each edge:
//     flush_i | jump_i | branch_taken_i: load NOP_INSTR, valid=0, pc4=pc_plus4_i.
//     else stall_i: hold all three fields.
//     else: load instr_i, pc_plus4_i, valid=1.
//   Latency: instruction fetched at PC p appears on if_id_* one edge later.
//   A redirect takes effect on pc_o one edge after assertion, and costs 1 bubble.
//   Simultaneous stall_i and flush_i: flush wins for IF/ID; PC follows the priority list.
//   Wrap-around: PC 32'hFFFF_FFFC + 4 wraps to 0, no flag.
//   Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately (async).
// CONFIGURATION
//   PERF_CNT_EN defined:
//     fetch_cnt_o increments on every edge that loads IF/ID with valid=1.
//     stall_cnt_o increments on every edge in which stall_i=1 and no redirect occurs.
//     Both counters saturate at 32'hFFFF_FFFF.
//   PERF_CNT_EN undefined: no counter flops; both outputs are tied to 32'h0.
// STRUCTURE
//   Shared header pipeline_defs.vh: NOP_INSTR, RESET_PC defaults, FSM encodings (BOOT/RUN/HOLD), instruction width.
//   One sub-module, pc_reg: 32-bit register with async active-low reset to RESET_PC and a load enable.
//   Next-PC mux, IF/ID register, FSM and counters live in if_fetch_stage.
// TESTING
//   Release reset, instr_i=32'h2008_0005, no controls:
//     BOOT for 1 cycle, then pc_o=0,4,8.
//     if_id_instr_o=32'h2008_0005 with if_id_valid_o=1 one edge after pc_o=0.
//   stall_i=1 for 3 cycles at pc_o=8:
//     pc_o and if_id_* hold 3 edges.
//     stall_cnt_o +3, fetch_cnt_o unchanged (PERF_CNT_EN).
//   branch_taken_i=1, branch_target_i=32'h0000_0043 at pc_o=12:
//     next pc_o=32'h40; IF/ID gets NOP_INSTR with valid=0.
//   jump_i=1 (target 32'h100) and branch_taken_i=1 (target 32'h200) together: pc_o=32'h100.
//   stall_i=1 and flush_i=1 together: IF/ID=NOP with valid=0; pc_o held.
//   Assert rst_n=0 mid-stall: outputs reach reset values before the next clk edge; BOOT re-entered.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default reset PC and
// NOP encoding, instruction width, FSM encodings and the IF/ID entry layout.
package if_fetch_stage_pkg;

    localparam int          INSTR_W         = 32;
    localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEF   = 32'h0000_0000;    // sll $0,$0,0

    localparam logic [1:0]  ST_BOOT         = 2'd0;
    localparam logic [1:0]  ST_RUN          = 2'd1;
    localparam logic [1:0]  ST_HOLD         = 2'd2;

    typedef struct packed {
        logic [31:0]        pc4;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    // Redirect targets are always word aligned; low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter register: async active-low reset to RESET_PC, load enable.
module if_fetch_stage_pc_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // PC flop; holds its value whenever load is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= RESET_PC;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register,
// BOOT/RUN/HOLD sequencing and optional performance counters.
// Build option: define PERF_CNT_EN to include the fetch/stall counters;
// otherwise fetch_cnt_o and stall_cnt_o are tied to zero.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   BOOT  | one cycle after reset release; imem settles, PC and IF/ID held
//   RUN   | normal fetch
//   HOLD  | hazard unit stalling; PC/IF/ID held unless a redirect arrives
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               branch_taken_i,
    input  logic [31:0]        branch_target_i,
    input  logic               jump_i,
    input  logic [31:0]        jump_target_i,
    input  logic [31:0]        pc_plus4_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [31:0]        pc_o,
    output logic [31:0]        if_id_pc4_o,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic               if_id_valid_o,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        stall_cnt_o
);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        active;
    logic        redirect;
    logic        pc_load;
    logic [31:0] pc_nxt;
    if_id_t      if_id;

    assign active   = (state != ST_BOOT);
    assign redirect = jump_i | branch_taken_i;
    // A redirect overrides a stall; BOOT never moves the PC.
    assign pc_load  = active & (redirect | ~stall_i);

    // Next-PC select: jump > branch > sequential (stall handled by pc_load).
    always_comb begin
        pc_nxt = pc_plus4_i;
        if (jump_i)
            pc_nxt = word_align(jump_target_i);
        else if (branch_taken_i)
            pc_nxt = word_align(branch_target_i);
    end

    if_fetch_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pc_load),
        .d     (pc_nxt),
        .q     (pc_o)
    );

    // Sequencer next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN:  if (stall_i)  state_nxt = ST_HOLD;
            ST_HOLD: if (!stall_i) state_nxt = ST_RUN;
            default: state_nxt = ST_BOOT;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_BOOT;
        else
            state <= state_nxt;
    end

    // IF/ID register: squash on flush or redirect, hold on stall, else load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id.pc4   <= 32'h0;
            if_id.instr <= NOP_INSTR;
            if_id.valid <= 1'b0;
        end else if (active) begin
            if (flush_i | redirect) begin
                if_id.pc4   <= pc_plus4_i;
                if_id.instr <= NOP_INSTR;
                if_id.valid <= 1'b0;
            end else if (!stall_i) begin
                if_id.pc4   <= pc_plus4_i;
                if_id.instr <= instr_i;
                if_id.valid <= 1'b1;
            end
        end
    end

    assign if_id_pc4_o   = if_id.pc4;
    assign if_id_instr_o = if_id.instr;
    assign if_id_valid_o = if_id.valid;

`ifdef PERF_CNT_EN
    logic        fetch_inc;
    logic        stall_inc;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    assign fetch_inc = active & ~(flush_i | redirect) & ~stall_i;
    assign stall_inc = stall_i & ~redirect;

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (fetch_inc && fetch_cnt != 32'hFFFF_FFFF)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (stall_inc && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt;
    assign stall_cnt_o = stall_cnt;
`else
    assign fetch_cnt_o = 32'h0;
    assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed-vector bench for if_fetch_stage with hand-computed expectations.
module tb_if_fetch_stage;

`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic [31:0] pc_plus4_i;
    logic [31:0] instr_i;
    logic [31:0] pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        if_id_valid_o;
    logic [31:0] fetch_cnt_o;
    logic [31:0] stall_cnt_o;

    int total = 0;
    int bad   = 0;

    if_fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .pc_plus4_i      (pc_plus4_i),
        .instr_i         (instr_i),
        .pc_o            (pc_o),
        .if_id_pc4_o     (if_id_pc4_o),
        .if_id_instr_o   (if_id_instr_o),
        .if_id_valid_o   (if_id_valid_o),
        .fetch_cnt_o     (fetch_cnt_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PC adder and a simple instruction memory image.
    assign pc_plus4_i = pc_o + 32'd4;
    assign instr_i    = (pc_o == 32'h0) ? 32'h2008_0005 : {16'hAC00, pc_o[15:0]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                           input logic [31:0] instr, input logic valid,
                           input logic [31:0] fcnt, input logic [31:0] scnt);
        chk({tag, ".pc"},    pc_o,                  pc);
        chk({tag, ".pc4"},   if_id_pc4_o,           pc4);
        chk({tag, ".instr"}, if_id_instr_o,         instr);
        chk({tag, ".valid"}, {31'h0, if_id_valid_o}, {31'h0, valid});
        chk({tag, ".fcnt"},  fetch_cnt_o,           PERF ? fcnt : 32'h0);
        chk({tag, ".scnt"},  stall_cnt_o,           PERF ? scnt : 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input logic st, input logic fl, input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt);
        stall_i         = st;
        flush_i         = fl;
        branch_taken_i  = br;
        branch_target_i = bt;
        jump_i          = jp;
        jump_target_i   = jt;
    endtask

    initial begin
        rst_n = 1'b1;
        ctl(0, 0, 0, 32'h0, 0, 32'h0);
        #2 rst_n = 1'b0;
        #1 chk_all("reset", 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step();
        chk_all("in_reset", 32'h0, 32'h0, 32'h0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        step(); chk_all("boot",  32'h0, 32'h0, 32'h0, 0, 0, 0);
        step(); chk_all("run0",  32'h4, 32'h4, 32'h2008_0005, 1, 1, 0);
        step(); chk_all("run1",  32'h8, 32'h8, 32'hAC00_0004, 1, 2, 0);

        ctl(1, 0, 0, 32'h0, 0, 32'h0);
        step(); chk_all("stall1", 32'h8, 32'h8, 32'hAC00_0004, 1, 2, 1);
        step(); chk_all("stall2", 32'h8, 32'h8, 32'hAC00_0004, 1, 2, 2);
        step(); chk_all("stall3", 32'h8, 32'h8, 32'hAC00_0004, 1, 2, 3);

        ctl(0, 0, 0, 32'h0, 0, 32'h0);
        step(); chk_all("resume", 32'hC, 32'hC, 32'hAC00_0008, 1, 3, 3);

        ctl(0, 0, 1, 32'h0000_0043, 0, 32'h0);
        step(); chk_all("branch", 32'h40, 32'h10, 32'h0, 0, 3, 3);
        ctl(0, 0, 0, 32'h0, 0, 32'h0);
        step(); chk_all("post_br", 32'h44, 32'h44, 32'hAC00_0040, 1, 4, 3);

        ctl(0, 0, 1, 32'h200, 1, 32'h100);
        step(); chk_all("jmp_br", 32'h100, 32'h48, 32'h0, 0, 4, 3);
        ctl(0, 0, 0, 32'h0, 0, 32'h0);
        step(); chk_all("post_jmp", 32'h104, 32'h104, 32'hAC00_0100, 1, 5, 3);

        ctl(1, 1, 0, 32'h0, 0, 32'h0);
        step(); chk_all("st_fl", 32'h104, 32'h108, 32'h0, 0, 5, 4);
        ctl(1, 0, 0, 32'h0, 0, 32'h0);
        step(); chk_all("st_after_fl", 32'h104, 32'h108, 32'h0, 0, 5, 5);
        ctl(0, 0, 0, 32'h0, 0, 32'h0);
        step(); chk_all("resume2", 32'h108, 32'h108, 32'hAC00_0104, 1, 6, 5);

        ctl(1, 0, 0, 32'h0, 1, 32'h203);
        step(); chk_all("redir_stall", 32'h200, 32'h10C, 32'h0, 0, 6, 5);
        ctl(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFF);
        step(); chk_all("jmp_top", 32'hFFFF_FFFC, 32'h204, 32'h0, 0, 6, 5);
        ctl(0, 0, 0, 32'h0, 0, 32'h0);
        step(); chk_all("wrap", 32'h0, 32'h0, 32'hAC00_FFFC, 1, 7, 5);

        ctl(1, 0, 0, 32'h0, 0, 32'h0);
        step(); chk_all("pre_rst", 32'h0, 32'h0, 32'hAC00_FFFC, 1, 7, 6);
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 32'h0, 32'h0, 32'h0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ctl(0, 0, 0, 32'h0, 0, 32'h0);
        step(); chk_all("reboot", 32'h0, 32'h0, 32'h0, 0, 0, 0);
        step(); chk_all("rerun", 32'h4, 32'h4, 32'h2008_0005, 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
